riscv_rf_writeback: RTL

- Write-side front end of the triple-read/dual-write register file; owns both RF write ports.
- ALU results drive write port A. LSU load responses are buffered in a small FIFO and drive write port B.
- Keeps a per-register pending-load scoreboard so decode can detect RAW/WAW hazards on the three read addresses.
- Sits between EX/LSU and the register file.

---
 rtl/riscv_rf_wb_pkg.sv | 13 +
 rtl/riscv_rf_wb_fifo.sv | 83 ++++++++
 rtl/riscv_rf_writeback.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_rf_wb_pkg.sv
// Shared defaults and the write-request type for the register-file write-back block.
package riscv_rf_wb_pkg;

    localparam int unsigned RF_WB_ADDR_WIDTH     = 5;
    localparam int unsigned RF_WB_DATA_WIDTH     = 32;
    localparam int unsigned RF_WB_LSU_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [RF_WB_ADDR_WIDTH-1:0] rd;
        logic [RF_WB_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/riscv_rf_wb_fifo.sv
// Valid/ready FIFO of wb_req_t with a registered output slot; an empty FIFO forwards a push
// straight into the output register, so the earliest output is the cycle after the push.
module riscv_rf_wb_fifo
    import riscv_rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = RF_WB_LSU_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_valid,
    output logic    o_ready,
    input  wb_req_t i_data,
    output logic    o_valid,
    output wb_req_t o_data,
    input  logic    i_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    wb_req_t          r_out_data;

    logic w_push;
    logic w_load;
    logic w_pop;
    logic w_bypass;
    logic w_store;
    logic w_empty;

    assign o_ready  = (r_count != CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = i_valid && o_ready;
    // Output slot can take a new entry when it is being consumed or is empty.
    assign w_load   = i_ready || !r_out_valid;
    assign w_pop    = w_load && !w_empty;
    assign w_bypass = w_load && w_empty && w_push;
    assign w_store  = w_push && !w_bypass;

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_valid <= w_pop || w_bypass;
            end
            if (w_pop) begin
                r_out_data <= r_mem[r_rd_ptr];
            end else if (w_bypass) begin
                r_out_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/riscv_rf_writeback.sv
// Write-side front end of the register file: ALU on port A, buffered LSU loads on port B, plus a
// pending-load scoreboard. Define RF_WB_PROTOCOL_CHECK_EN to add the sticky err_o checker.
module riscv_rf_writeback
    import riscv_rf_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = RF_WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = RF_WB_DATA_WIDTH,
    parameter int unsigned LSU_FIFO_DEPTH = RF_WB_LSU_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,
    output logic [ADDR_WIDTH-1:0] waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o
`ifdef RF_WB_PROTOCOL_CHECK_EN
    ,
    output logic                  err_o
`endif
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;

    // wb_req_t is sized from the package, so the instance widths must agree with it.
    if (ADDR_WIDTH != RF_WB_ADDR_WIDTH || DATA_WIDTH != RF_WB_DATA_WIDTH) begin : g_bad_width
        $error("riscv_rf_writeback: widths must match riscv_rf_wb_pkg");
    end
    if (LSU_FIFO_DEPTH < 2 || (LSU_FIFO_DEPTH & (LSU_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("riscv_rf_writeback: LSU_FIFO_DEPTH must be a power of 2 and >= 2");
    end

    wb_req_t r_port_a;
    logic    r_we_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_a   <= 1'b0;
            r_port_a <= '0;
        end else begin
            r_we_a <= alu_valid_i && (alu_rd_i != '0);
            if (alu_valid_i) begin
                r_port_a <= '{rd: alu_rd_i, wdata: alu_wdata_i};
            end
        end
    end

    assign we_a_o    = r_we_a;
    assign waddr_a_o = r_port_a.rd;
    assign wdata_a_o = r_port_a.wdata;

    wb_req_t w_lsu_req;
    wb_req_t w_port_b;
    logic    w_port_b_valid;

    assign w_lsu_req = '{rd: lsu_rd_i, wdata: lsu_wdata_i};

    riscv_rf_wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (lsu_valid_i),
        .o_ready (lsu_ready_o),
        .i_data  (w_lsu_req),
        .o_valid (w_port_b_valid),
        .o_data  (w_port_b),
        .i_ready (1'b1)
    );

    // x0 loads still drain from the FIFO, they just never strobe the RF.
    assign we_b_o    = w_port_b_valid && (w_port_b.rd != '0);
    assign waddr_b_o = w_port_b.rd;
    assign wdata_b_o = w_port_b.wdata;

    logic [NUM_WORDS-1:1] r_busy;
    logic [NUM_WORDS-1:1] w_busy_nxt;
    logic [NUM_WORDS-1:0] w_busy_vec;

    always_comb begin
        w_busy_nxt = r_busy;
        if (we_b_o) begin
            w_busy_nxt[waddr_b_o] = 1'b0;
        end
        // A new issue to the register being written back keeps it pending.
        if (issue_valid_i && (issue_rd_i != '0)) begin
            w_busy_nxt[issue_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_busy_vec = {r_busy, 1'b0};
    assign busy_a_o   = w_busy_vec[raddr_a_i];
    assign busy_b_o   = w_busy_vec[raddr_b_i];
    assign busy_c_o   = w_busy_vec[raddr_c_i];

`ifdef RF_WB_PROTOCOL_CHECK_EN
    logic r_err;
    logic w_err_issue;
    logic w_err_lsu;
    logic w_err_waw;

    assign w_err_issue = issue_valid_i && w_busy_vec[issue_rd_i];
    assign w_err_lsu   = lsu_valid_i && lsu_ready_o && !w_busy_vec[lsu_rd_i];
    assign w_err_waw   = r_we_a && we_b_o && (waddr_a_o == waddr_b_o);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_issue || w_err_lsu || w_err_waw) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule
